// File: rtl/processor_pkg.sv
// Shared types and helpers for the processor run monitor.
// Optional PC trace is enabled by defining PC_TRACE_EN.
package processor_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RUN     = 3'd2,
    HALTED  = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  localparam int DEF_PC_W     = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 16;

  // Index width for v entries, never below one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pc_trace_buffer.sv
// Circular buffer of recent PCs, read relative to the oldest entry.
// Instantiated only when PC_TRACE_EN is defined.
module pc_trace_buffer
  import processor_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int DEPTH = 8,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic [AW-1:0]   rd_idx,
  output logic [PC_W-1:0] rd_data,
  output logic [AW:0]     count
);

  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   oldest;
  logic [AW-1:0]   addr;

  assign oldest = (count == (AW+1)'(DEPTH)) ? wptr : '0;
  assign addr   = oldest + rd_idx;

  // PC storage, contents qualified by count
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_pc;
  end

  // write pointer and saturating fill count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      count <= '0;
    end else if (wr_en) begin
      wptr <= wptr + AW'(1);
      if (count != (AW+1)'(DEPTH))
        count <= count + (AW+1)'(1);
    end
  end

  // registered oldest-relative read
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_data <= '0;
    else if ({1'b0, rd_idx} < count)
      rd_data <= mem[addr];
    else
      rd_data <= '0;
  end

endmodule

// File: rtl/processor_run_monitor.sv
// Run control and halt/timeout detection around the tiny core.
// Define PC_TRACE_EN to build the PC trace buffer.
module processor_run_monitor
  import processor_pkg::*;
#(
  parameter int PC_W           = DEF_PC_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int NUM_REGS       = DEF_NUM_REGS,
  parameter int RESET_CYCLES   = 2,
  parameter int HALT_STABLE    = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16,
  parameter int TRACE_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [PC_W-1:0]              pc,
  input  logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  input  logic                         cb_in,
  output logic                         core_reset,
  output logic                         running,
  output logic                         done,
  output logic                         timed_out,
  output logic [PC_W-1:0]              halt_pc,
  output logic [CNT_W-1:0]             cycle_count,
  output logic                         snap_cb,
  input  logic [clog2(NUM_REGS)-1:0]   rd_idx,
  output logic [DATA_W-1:0]            rd_data,
  input  logic [clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [PC_W-1:0]              trace_data,
  output logic [clog2(TRACE_DEPTH):0]  trace_count
);

  state_t                     state;
  state_t                     state_nxt;
  logic [PC_W-1:0]            pc_prev;
  logic                       first;
  logic [CNT_W-1:0]           hold_cnt;
  logic [CNT_W-1:0]           stable;
  logic [CNT_W-1:0]           stable_nxt;
  logic [NUM_REGS*DATA_W-1:0] snap_flat;
  logic                       start_go;
  logic                       enter_hold;
  logic                       capture;

  assign start_go   = start & ~abort;
  assign enter_hold = (state_nxt == HOLD) && (state != HOLD);

  assign core_reset = (state == IDLE) || (state == HOLD);
  assign running    = (state == RUN);
  assign done       = (state == HALTED) || (state == TIMEOUT);
  assign timed_out  = (state == TIMEOUT);

  // unchanged-PC run length including this cycle
  always_comb begin
    stable_nxt = '0;
    if (!first && pc == pc_prev)
      stable_nxt = stable + CNT_W'(1);
  end

  // next state; halt has priority over timeout
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      IDLE:
        if (start_go) state_nxt = HOLD;
      HOLD:
        if (abort)
          state_nxt = IDLE;
        else if (hold_cnt == CNT_W'(RESET_CYCLES - 1))
          state_nxt = RUN;
      RUN:
        if (abort) begin
          state_nxt = IDLE;
        end else if (stable_nxt == CNT_W'(HALT_STABLE)) begin
          state_nxt = HALTED;
          capture   = 1'b1;
        end else if (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = TIMEOUT;
          capture   = 1'b1;
        end
      HALTED, TIMEOUT:
        if (start_go) state_nxt = HOLD;
      default:
        state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // hold, stable and cycle counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_prev     <= '0;
      first       <= 1'b1;
      hold_cnt    <= '0;
      stable      <= '0;
      cycle_count <= '0;
    end else begin
      pc_prev <= pc;
      first   <= (state != RUN);
      if (enter_hold) begin
        hold_cnt    <= '0;
        stable      <= '0;
        cycle_count <= '0;
      end else if (state == HOLD) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end else if (state == RUN) begin
        stable <= stable_nxt;
        if (state_nxt == RUN && cycle_count != '1)
          cycle_count <= cycle_count + CNT_W'(1);
      end
    end
  end

  // end-of-run snapshot, frozen until the next end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_pc   <= '0;
      snap_cb   <= 1'b0;
      snap_flat <= '0;
    end else if (capture) begin
      halt_pc   <= pc;
      snap_cb   <= cb_in;
      snap_flat <= regs_flat;
    end
  end

  // registered snapshot read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_data <= '0;
    else if (int'(rd_idx) < NUM_REGS)
      rd_data <= snap_flat[int'(rd_idx)*DATA_W +: DATA_W];
    else
      rd_data <= '0;
  end

`ifdef PC_TRACE_EN
  logic trace_wr;
  assign trace_wr = (state == RUN) && (first || pc != pc_prev);

  pc_trace_buffer #(
    .PC_W  (PC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .reset   (reset),
    .clear   (enter_hold),
    .wr_en   (trace_wr),
    .wr_pc   (pc),
    .rd_idx  (trace_idx),
    .rd_data (trace_data),
    .count   (trace_count)
  );
`else
  logic unused_trace;
  assign unused_trace = ^trace_idx;
  assign trace_data   = '0;
  assign trace_count  = '0;
`endif

endmodule
